// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: FIFO-buffered 8N1 serialiser with a polled STATUS byte.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_periph #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [9:0]  ADDR_DATA    = 10'h54,
  parameter logic [9:0]  ADDR_STATUS  = 10'h58
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] address,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] read_data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned CNTW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_FLAG = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic PAR_FLAG = 1'b0;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push_req, push, pop, clr, overflow;
  logic [7:0]      head, status;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            bit_last;
`ifdef UART_TX_PARITY_EN
  logic            par;
`endif

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push_req = write && (address == ADDR_DATA);
  assign push     = push_req && !full;
  assign clr      = write && (address == ADDR_STATUS);
  assign head     = mem[rd_ptr];
  assign bit_last = (cnt == CNT_LAST);
  // Pop either from idle or on the final stop-bit cycle, giving back-to-back frames.
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_last));
  assign status   = {3'b000, PAR_FLAG, (state != IDLE), overflow, empty, full};
  assign busy     = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped push outranks a clear arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst)                   overflow <= 1'b0;
    else if (push_req && full) overflow <= 1'b1;
    else if (clr)              overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) read_data <= '0;
    else     read_data <= (address == ADDR_STATUS) ? status : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (!empty) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            par   <= ^head;
`endif
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (bit_last) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shift[0];
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        DATA: begin
          if (bit_last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_last) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_last) begin
            cnt <= '0;
            if (!empty) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              par   <= ^head;
`endif
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register-access vector table plus frame, reset and overflow sequences.
module tb_uart_tx_periph;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int         FL = 11 * CPB;
  localparam logic [7:0] PB = 8'h10;
  localparam bit         HAS_PAR = 1'b1;
`else
  localparam int         FL = 10 * CPB;
  localparam logic [7:0] PB = 8'h00;
  localparam bit         HAS_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, write;
  logic [9:0] address;
  logic [7:0] data_in;
  logic [7:0] read_data, s_read_data;
  logic       tx, busy, s_tx, s_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .ADDR_DATA(10'h54), .ADDR_STATUS(10'h58)) dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .write(write),
    .read_data(read_data), .tx(tx), .busy(busy));

  // Shared address for data and status so one store both drops a push and requests a clear.
  uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(2), .ADDR_DATA(10'h54), .ADDR_STATUS(10'h54)) dut_s (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .write(write),
    .read_data(s_read_data), .tx(s_tx), .busy(s_busy));

  typedef struct {
    logic [9:0] addr;
    logic       wr;
    logic [7:0] din;
    logic [7:0] exp_rd;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [9:0] a, input logic w, input logic [7:0] d,
                              input logic [7:0] rd, input logic b);
    vec_t v;
    v.addr = a; v.wr = w; v.din = d; v.exp_rd = rd; v.exp_busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; write = 1'b0; address = '0; data_in = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected line level at position pos (0-based) within one frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int pos);
    int slot;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && HAS_PAR) return ^b;
    return 1'b1;
  endfunction

  // Push b0 (and b1 on the next edge when n==2), then follow the line cycle by cycle.
  task automatic run_frames(input logic [7:0] b0, input logic [7:0] b1, input int n, input string tag);
    logic [7:0] b;
    write = 1'b1; address = 10'h54; data_in = b0;
    step();
    for (int k = 1; k <= n * FL + 1; k++) begin
      if (k == 1 && n == 2) begin
        write = 1'b1; data_in = b1;
      end else begin
        write = 1'b0;
      end
      step();
      if (k <= n * FL) begin
        b = ((k - 1) / FL == 0) ? b0 : b1;
        chk($sformatf("%s_tx_k%0d", tag, k), 8'(tx), 8'(exp_tx(b, (k - 1) % FL)));
        chk($sformatf("%s_busy_k%0d", tag, k), 8'(busy), 8'd1);
      end else begin
        chk($sformatf("%s_tx_idle", tag), 8'(tx), 8'd1);
        chk($sformatf("%s_busy_end", tag), 8'(busy), 8'd0);
      end
    end
  endtask

  initial begin
    do_reset();
    chk("rst_tx", 8'(tx), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_rd", read_data, 8'h00);

    vecs.push_back(mk(10'h58, 1'b0, 8'h00, 8'h02 | PB, 1'b0));
    vecs.push_back(mk(10'h10, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(10'h54, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(10'h59, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(10'h58, 1'b1, 8'hFF, 8'h02 | PB, 1'b0));
    vecs.push_back(mk(10'h58, 1'b0, 8'h00, 8'h02 | PB, 1'b0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(10'h54, 1'b1, 8'(8'h30 + i), 8'h00, 1'b1));
    vecs.push_back(mk(10'h58, 1'b0, 8'h00, 8'h09 | PB, 1'b1));
    vecs.push_back(mk(10'h54, 1'b1, 8'hEE, 8'h00, 1'b1));
    vecs.push_back(mk(10'h58, 1'b0, 8'h00, 8'h0D | PB, 1'b1));
    vecs.push_back(mk(10'h58, 1'b1, 8'h00, 8'h0D | PB, 1'b1));
    vecs.push_back(mk(10'h58, 1'b0, 8'h00, 8'h09 | PB, 1'b1));
    vecs.push_back(mk(10'h3C, 1'b0, 8'h00, 8'h00, 1'b1));

    foreach (vecs[i]) begin
      address = vecs[i].addr; write = vecs[i].wr; data_in = vecs[i].din;
      step();
      chk($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_busy", i), 8'(busy), 8'(vecs[i].exp_busy));
    end
    write = 1'b0;

    do_reset();
    run_frames(8'hA5, 8'h00, 1, "a5");

    do_reset();
    run_frames(8'h01, 8'h02, 2, "pair");

    // Abort mid-DATA with three bytes still queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; address = 10'h54; data_in = 8'(8'h11 * (i + 1));
      step();
    end
    write = 1'b0;
    repeat (12) step();
    rst = 1'b1; address = 10'h58;
    step();
    chk("midrst_tx", 8'(tx), 8'd1);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_rd", read_data, 8'h00);
    rst = 1'b0;
    step();
    chk("midrst_status", read_data, 8'h02 | PB);
    address = 10'h00;
    for (int k = 0; k < 60; k++) begin
      step();
      chk($sformatf("midrst_quiet_tx%0d", k), 8'(tx), 8'd1);
      chk($sformatf("midrst_quiet_busy%0d", k), 8'(busy), 8'd0);
    end

    // Same-edge dropped push and clear on the shared-address instance.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; address = 10'h54; data_in = 8'(8'h40 + i);
      step();
    end
    write = 1'b0;
    step();
    chk("samedge_pre", s_read_data, 8'h09 | PB);
    write = 1'b1; data_in = 8'h77;
    step();
    write = 1'b0;
    step();
    chk("samedge_ovf", s_read_data, 8'h0D | PB);
    chk("samedge_busy", 8'(s_busy), 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
